// File: rtl/noc16_block_engine.sv
// NOC16 block engine: collects key/IV/mode/data beats, applies a fixed-latency
// XOR transform with optional CBC chaining, and returns the block over TX.
module noc16_block_engine #(
  parameter int          DATA_W      = 64,
  parameter int          BLOCK_BEATS = 2,
  parameter int          KEY_BEATS   = 22,
  parameter int          LATENCY     = 10,
  parameter logic [23:0] SERIAL      = 24'd9
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] rx_lo,
  input  logic [7:0]        rx_cmd,
  input  logic              rx_valid,
  output logic              rx_rdy,
  output logic [DATA_W-1:0] tx_lo,
  output logic [7:0]        tx_cmd,
  output logic              tx_valid,
  input  logic              tx_rdy,
  output logic [23:0]       designSerialNumber,
  output logic              busy,
  output logic [7:0]        err_count
);

  localparam int BW    = DATA_W * BLOCK_BEATS;
  localparam int BB_W  = (BLOCK_BEATS > 1) ? $clog2(BLOCK_BEATS) : 1;
  localparam int IV_W  = $clog2(BLOCK_BEATS + 1);
  localparam int KI_W  = $clog2(KEY_BEATS + 1);
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  localparam logic [BB_W-1:0]  LAST_BEAT = BB_W'(BLOCK_BEATS - 1);
  localparam logic [IV_W-1:0]  IV_LAST   = IV_W'(BLOCK_BEATS - 1);
  localparam logic [IV_W-1:0]  IV_FULL   = IV_W'(BLOCK_BEATS);
  localparam logic [KI_W-1:0]  KEY_FULL  = KI_W'(KEY_BEATS);
  localparam logic [CNT_W-1:0] CNT_LOAD  = CNT_W'(LATENCY - 1);

  localparam logic [7:0] CMD_KEY   = 8'd0;
  localparam logic [7:0] CMD_IV    = 8'd1;
  localparam logic [7:0] CMD_DATA  = 8'd2;
  localparam logic [7:0] CMD_MODE  = 8'd3;
  localparam logic [7:0] CMD_CLEAR = 8'd4;

  typedef enum logic [1:0] {IDLE, COLLECT, PROC, SEND} state_t;

  state_t           state_q, state_d;
  logic             rxRdy_q, rxRdy_d;
  logic [23:0]      serial_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [BB_W-1:0]  txBeat_q, txBeat_d;
  logic [BB_W-1:0]  inIdx_q, inIdx_d;
  logic [IV_W-1:0]  ivIdx_q, ivIdx_d;
  logic [KI_W-1:0]  keyIdx_q, keyIdx_d;
  logic             cbc_q, cbc_d;
  logic [BW-1:0]    chain_q, chain_d;
  logic [BW-1:0]    outReg_q, outReg_d;
  logic [7:0]       errCount_q, errCount_d;

  logic [DATA_W-1:0] keyStore_q [KEY_BEATS];
  logic [DATA_W-1:0] ivStore_q  [BLOCK_BEATS];
  logic [DATA_W-1:0] blkBuf_q   [BLOCK_BEATS];

  logic          keyWe, ivWe, bufWe;
  logic          accept;
  logic [BW-1:0] newBlock, keyBlock, ivBlock, transformed;
  logic [DATA_W-1:0] txSel;

  assign accept = rx_valid && rxRdy_q;

  // The incoming beat completes the block in the same cycle it is written.
  always_comb begin
    newBlock = '0;
    keyBlock = '0;
    ivBlock  = '0;
    for (int b = 0; b < BLOCK_BEATS; b++) begin
      newBlock[b*DATA_W +: DATA_W] = (b == BLOCK_BEATS - 1) ? rx_lo : blkBuf_q[b];
      ivBlock[b*DATA_W +: DATA_W]  = (b == BLOCK_BEATS - 1) ? rx_lo : ivStore_q[b];
      keyBlock[b*DATA_W +: DATA_W] = keyStore_q[b];
    end
    transformed = newBlock ^ keyBlock ^ (cbc_q ? chain_q : '0);
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    txBeat_d   = txBeat_q;
    inIdx_d    = inIdx_q;
    ivIdx_d    = ivIdx_q;
    keyIdx_d   = keyIdx_q;
    cbc_d      = cbc_q;
    chain_d    = chain_q;
    outReg_d   = outReg_q;
    errCount_d = errCount_q;
    keyWe      = 1'b0;
    ivWe       = 1'b0;
    bufWe      = 1'b0;

    case (state_q)
      IDLE, COLLECT: begin
        if (accept) begin
          case (rx_cmd)
            CMD_KEY: begin
              if (keyIdx_q != KEY_FULL) begin
                keyWe    = 1'b1;
                keyIdx_d = keyIdx_q + KI_W'(1);
              end
            end
            CMD_IV: begin
              if (ivIdx_q != IV_FULL) begin
                ivWe    = 1'b1;
                ivIdx_d = ivIdx_q + IV_W'(1);
                if (ivIdx_q == IV_LAST) chain_d = ivBlock;
              end
            end
            CMD_DATA: begin
              bufWe = 1'b1;
              if (inIdx_q == LAST_BEAT) begin
                state_d  = PROC;
                cnt_d    = CNT_LOAD;
                outReg_d = transformed;
                if (cbc_q) chain_d = transformed;
              end else begin
                inIdx_d = inIdx_q + BB_W'(1);
                state_d = COLLECT;
              end
            end
            CMD_MODE: cbc_d = rx_lo[0];
            CMD_CLEAR: begin
              keyIdx_d = '0;
              ivIdx_d  = '0;
              inIdx_d  = '0;
              chain_d  = '0;
              state_d  = IDLE;
            end
            default: begin
              if (errCount_q != 8'hFF) errCount_d = errCount_q + 8'd1;
            end
          endcase
        end
      end
      PROC: begin
        if (cnt_q == '0) begin
          state_d  = SEND;
          txBeat_d = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      SEND: begin
        if (tx_rdy) begin
          if (txBeat_q == LAST_BEAT) begin
            state_d = IDLE;
            inIdx_d = '0;
          end else begin
            txBeat_d = txBeat_q + BB_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    rxRdy_d = (state_d == IDLE) || (state_d == COLLECT);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      rxRdy_q    <= 1'b0;
      serial_q   <= '0;
      cnt_q      <= '0;
      txBeat_q   <= '0;
      inIdx_q    <= '0;
      ivIdx_q    <= '0;
      keyIdx_q   <= '0;
      cbc_q      <= 1'b0;
      chain_q    <= '0;
      outReg_q   <= '0;
      errCount_q <= '0;
    end else begin
      state_q    <= state_d;
      rxRdy_q    <= rxRdy_d;
      serial_q   <= SERIAL;
      cnt_q      <= cnt_d;
      txBeat_q   <= txBeat_d;
      inIdx_q    <= inIdx_d;
      ivIdx_q    <= ivIdx_d;
      keyIdx_q   <= keyIdx_d;
      cbc_q      <= cbc_d;
      chain_q    <= chain_d;
      outReg_q   <= outReg_d;
      errCount_q <= errCount_d;
    end
  end

  // Key, IV and block storage carry no reset; contents are only meaningful once written.
  always_ff @(posedge clk) begin
    for (int k = 0; k < KEY_BEATS; k++)
      if (keyWe && keyIdx_q == KI_W'(k)) keyStore_q[k] <= rx_lo;
    for (int b = 0; b < BLOCK_BEATS; b++) begin
      if (ivWe && ivIdx_q == IV_W'(b)) ivStore_q[b] <= rx_lo;
      if (bufWe && inIdx_q == BB_W'(b)) blkBuf_q[b] <= rx_lo;
    end
  end

  always_comb begin
    txSel = '0;
    for (int b = 0; b < BLOCK_BEATS; b++)
      if (txBeat_q == BB_W'(b)) txSel = outReg_q[b*DATA_W +: DATA_W];
  end

  assign rx_rdy             = rxRdy_q;
  assign tx_valid           = (state_q == SEND);
  assign tx_cmd             = (state_q == SEND) ? 8'hFF : 8'h00;
  assign tx_lo              = (state_q == SEND) ? txSel : '0;
  assign designSerialNumber = serial_q;
  assign busy               = (state_q != IDLE);
  assign err_count          = errCount_q;

endmodule

// File: tb/tb_noc16_block_engine.sv
// Directed bench for noc16_block_engine: table of ECB blocks plus hand-written
// sequences for latency, back-pressure, CBC, error saturation and mid-run reset.
module tb_noc16_block_engine;

  localparam int LAT = 10;

  logic        clk;
  logic        reset_n;
  logic [63:0] rx_lo;
  logic [7:0]  rx_cmd;
  logic        rx_valid;
  logic        rx_rdy;
  logic [63:0] tx_lo;
  logic [7:0]  tx_cmd;
  logic        tx_valid;
  logic        tx_rdy;
  logic [23:0] designSerialNumber;
  logic        busy;
  logic [7:0]  err_count;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int lastEdge = 0;

  typedef struct {
    logic [63:0] key0;
    logic [63:0] key1;
    logic [63:0] data0;
    logic [63:0] data1;
    logic [63:0] exp0;
    logic [63:0] exp1;
  } vec_t;

  vec_t vecs [4];

  noc16_block_engine #(
    .DATA_W(64), .BLOCK_BEATS(2), .KEY_BEATS(22), .LATENCY(LAT), .SERIAL(24'd9)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .rx_lo(rx_lo), .rx_cmd(rx_cmd), .rx_valid(rx_valid), .rx_rdy(rx_rdy),
    .tx_lo(tx_lo), .tx_cmd(tx_cmd), .tx_valid(tx_valid), .tx_rdy(tx_rdy),
    .designSerialNumber(designSerialNumber), .busy(busy), .err_count(err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Presents one beat starting at a negedge; returns at the negedge after acceptance.
  task automatic applyStimulus(input logic [7:0] cmd, input logic [63:0] data);
    int guard = 0;
    while (!rx_rdy && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (!rx_rdy) begin
      checks++;
      errors++;
      $display("[TB] FAIL rx_rdy_timeout: got 0, expected 1 within 200 cycles");
    end
    rx_cmd   = cmd;
    rx_lo    = data;
    rx_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rx_valid = 1'b0;
    lastEdge = cyc;
  endtask

  task automatic waitTxValid(output int latency);
    int guard = 0;
    while (!tx_valid && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    latency = cyc - lastEdge;
    if (!tx_valid) begin
      checks++;
      errors++;
      $display("[TB] FAIL tx_valid_timeout: got 0, expected 1 within 200 cycles");
    end
  endtask

  // Gathers two TX beats with tx_rdy high; ends at the negedge after the last handshake.
  task automatic collectTx(input string name, output logic [63:0] b0, output logic [63:0] b1);
    int n = 0;
    int guard = 0;
    b0 = '0;
    b1 = '0;
    tx_rdy = 1'b1;
    while (n < 2 && guard < 200) begin
      if (tx_valid) begin
        if (n == 0) b0 = tx_lo;
        else        b1 = tx_lo;
        checkOutput($sformatf("%s_txcmd%0d", name, n), 64'(tx_cmd), 64'hFF);
        n++;
      end
      @(negedge clk);
      guard++;
    end
    if (n < 2) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s_tx_timeout: got %0d beats, expected 2", name, n);
    end
  endtask

  task automatic runBlock(input string name, input logic [63:0] d0, input logic [63:0] d1,
                          input logic [63:0] e0, input logic [63:0] e1, input bit checkLat);
    int lat;
    logic [63:0] b0, b1;
    applyStimulus(8'd2, d0);
    applyStimulus(8'd2, d1);
    checkOutput({name, "_rdy_low"}, 64'(rx_rdy), 64'd0);
    waitTxValid(lat);
    if (checkLat) checkOutput({name, "_latency"}, 64'(lat), 64'(LAT));
    collectTx(name, b0, b1);
    checkOutput({name, "_beat0"}, b0, e0);
    checkOutput({name, "_beat1"}, b1, e1);
    checkOutput({name, "_idle_rdy"}, 64'(rx_rdy), 64'd1);
    checkOutput({name, "_idle_busy"}, 64'(busy), 64'd0);
  endtask

  task automatic checkAllZero(input string name);
    checkOutput({name, "_rx_rdy"}, 64'(rx_rdy), 64'd0);
    checkOutput({name, "_tx_valid"}, 64'(tx_valid), 64'd0);
    checkOutput({name, "_tx_lo"}, tx_lo, 64'd0);
    checkOutput({name, "_tx_cmd"}, 64'(tx_cmd), 64'd0);
    checkOutput({name, "_serial"}, 64'(designSerialNumber), 64'd0);
    checkOutput({name, "_busy"}, 64'(busy), 64'd0);
    checkOutput({name, "_err_count"}, 64'(err_count), 64'd0);
  endtask

  initial begin
    vecs[0] = '{64'h0, 64'h0, 64'h1111, 64'h2222, 64'h1111, 64'h2222};
    vecs[1] = '{64'hFF00, 64'hFF00, 64'h0F0F, 64'h0F0F, 64'hF00F, 64'hF00F};
    vecs[2] = '{64'h0123456789ABCDEF, 64'hFEDCBA9876543210, 64'hFFFFFFFFFFFFFFFF, 64'h0,
                64'hFEDCBA9876543210, 64'hFEDCBA9876543210};
    vecs[3] = '{64'hA5A5A5A5A5A5A5A5, 64'h5A5A5A5A5A5A5A5A, 64'h5A5A5A5A5A5A5A5A, 64'hA5A5A5A5A5A5A5A5,
                64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF};

    reset_n  = 1'b0;
    rx_valid = 1'b0;
    rx_cmd   = '0;
    rx_lo    = '0;
    tx_rdy   = 1'b1;
    repeat (2) @(negedge clk);
    checkAllZero("reset");
    reset_n = 1'b1;
    @(negedge clk);
    checkOutput("post_reset_rx_rdy", 64'(rx_rdy), 64'd1);
    checkOutput("post_reset_serial", 64'(designSerialNumber), 64'd9);

    // ECB with a fully zero key store; the surplus key beat must be dropped.
    applyStimulus(8'd4, 64'd0);
    applyStimulus(8'd3, 64'd0);
    for (int k = 0; k < 22; k++) applyStimulus(8'd0, 64'd0);
    applyStimulus(8'd0, 64'hDEAD);
    runBlock("ecb_zero", 64'h1111, 64'h2222, 64'h1111, 64'h2222, 1'b1);

    for (int i = 0; i < 4; i++) begin
      applyStimulus(8'd4, 64'd0);
      applyStimulus(8'd3, 64'd0);
      applyStimulus(8'd0, vecs[i].key0);
      applyStimulus(8'd0, vecs[i].key1);
      runBlock($sformatf("vec%0d", i), vecs[i].data0, vecs[i].data1, vecs[i].exp0, vecs[i].exp1, 1'b1);
    end

    // Back-pressure: first beat must hold while tx_rdy stays low.
    begin
      int lat;
      logic [63:0] b0, b1;
      applyStimulus(8'd4, 64'd0);
      applyStimulus(8'd3, 64'd0);
      applyStimulus(8'd0, 64'd0);
      applyStimulus(8'd0, 64'd0);
      tx_rdy = 1'b0;
      applyStimulus(8'd2, 64'hAAAA);
      applyStimulus(8'd2, 64'hBBBB);
      waitTxValid(lat);
      checkOutput("bp_latency", 64'(lat), 64'(LAT));
      for (int c = 0; c < 5; c++) begin
        checkOutput($sformatf("bp_hold%0d_valid", c), 64'(tx_valid), 64'd1);
        checkOutput($sformatf("bp_hold%0d_lo", c), tx_lo, 64'hAAAA);
        checkOutput($sformatf("bp_hold%0d_rx_rdy", c), 64'(rx_rdy), 64'd0);
        @(negedge clk);
      end
      collectTx("bp", b0, b1);
      checkOutput("bp_beat0", b0, 64'hAAAA);
      checkOutput("bp_beat1", b1, 64'hBBBB);
      checkOutput("bp_idle_rdy", 64'(rx_rdy), 64'd1);
    end

    // Unknown commands saturate the error counter without leaving IDLE.
    for (int i = 0; i < 300; i++) begin
      applyStimulus(8'd7, 64'(i));
      if (i == 99) checkOutput("err_count_100", 64'(err_count), 64'd100);
    end
    checkOutput("err_count_sat", 64'(err_count), 64'd255);
    checkOutput("err_busy", 64'(busy), 64'd0);
    checkOutput("err_rx_rdy", 64'(rx_rdy), 64'd1);

    // CBC: IV {2,1}, surplus IV beat dropped, two chained blocks.
    applyStimulus(8'd4, 64'd0);
    applyStimulus(8'd0, 64'd0);
    applyStimulus(8'd0, 64'd0);
    applyStimulus(8'd1, 64'h1);
    applyStimulus(8'd1, 64'h2);
    applyStimulus(8'd1, 64'h3);
    applyStimulus(8'd3, 64'd1);
    runBlock("cbc_blk1", 64'h10, 64'h20, 64'h11, 64'h22, 1'b0);
    runBlock("cbc_blk2", 64'h10, 64'h20, 64'h01, 64'h02, 1'b0);

    // Reset three cycles into PROC, then a fresh block in the default (ECB) mode.
    applyStimulus(8'd2, 64'h5);
    applyStimulus(8'd2, 64'h6);
    repeat (3) @(negedge clk);
    checkOutput("midproc_busy", 64'(busy), 64'd1);
    reset_n = 1'b0;
    #1;
    checkAllZero("midproc_reset");
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    checkOutput("midproc_release_rdy", 64'(rx_rdy), 64'd1);
    applyStimulus(8'd0, 64'h0F00);
    applyStimulus(8'd0, 64'h00F0);
    runBlock("after_reset", 64'h1234, 64'h5678, 64'h1D34, 64'h5688, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
